// File: rtl/ufm_event_log.sv
// ufm_event_log
//   Watches a GPI vector and, on any change while saving is enabled, snapshots
//   it into a ring of UFM slots. Each 128-bit page is staged through the
//   16-byte DPRAM port B (FILL), then committed with a page-write command to
//   ufm_wb_top (KICK / WHI / WLO), with per-page retry on ERR and a watchdog
//   on BUSY rising. A rising edge on erase_req_i queues a full erase that
//   resets the ring.
//
//   Optional macro UFM_LOG_HDR_EN: each snapshot is preceded by a header page
//   {seq[31:0] MSB first, NPG, 10 x 0x00, 0xA5}.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_save_i           enables change detection
//   erase_req_i         level request; rising edge queues an erase
//   gpi                 monitored vector (GPI_W bits, synchronous)
//   cmd/ufm_page/GO     command interface to ufm_wb_top (2 = write, 4 = erase)
//   BUSY/ERR            ufm_wb_top status, ERR valid on BUSY falling
//   mem_*               DPRAM port B (write-only use; mem_rd_data unused)
//   busy_o              high outside IDLE
//   save_done_o         one-cycle pulse per completed snapshot
//   err_o, wrap_o       sticky error / ring-wrapped flags
//   slot_o              next slot to write
module ufm_event_log #(
  parameter int          GPI_W     = 512,
  parameter int          NUM_SLOTS = 8,
  parameter logic [10:0] BASE_PAGE = 11'd0,
  parameter int          MAX_RETRY = 2,
  parameter int          TMO       = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_save_i,
  input  logic                         erase_req_i,
  input  logic [GPI_W-1:0]             gpi,
  output logic [2:0]                   cmd,
  output logic [10:0]                  ufm_page,
  output logic                         GO,
  input  logic                         BUSY,
  input  logic                         ERR,
  output logic                         mem_we,
  output logic                         mem_ce,
  output logic [3:0]                   mem_addr,
  output logic [7:0]                   mem_wr_data,
  input  logic [7:0]                   mem_rd_data,
  output logic                         busy_o,
  output logic                         save_done_o,
  output logic                         err_o,
  output logic                         wrap_o,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_o
);
  localparam int NPG = GPI_W / 128;
`ifdef UFM_LOG_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int SLOT_PG = NPG + HDR;
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int GW = $clog2(SLOT_PG + 1);
  localparam int PW = (NPG > 1) ? $clog2(NPG) : 1;
  localparam int TW = $clog2(TMO + 2);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_KICK, S_WHI, S_WLO, S_NEXT, S_DONE, S_EKICK, S_EHI, S_ELO
  } state_t;

  state_t                        state_q, state_d;
  logic [3:0]                    byte_q, byte_d;
  logic [GW-1:0]                 pg_q, pg_d;
  logic [10:0]                   page_q, page_d;
  logic [RW-1:0]                 retry_q, retry_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic [SW-1:0]                 slot_q, slot_d;
  logic                          wrap_q, wrap_d;
  logic                          err_q, err_d;
  logic                          init_q, init_d;
  logic                          erq_q, erq_d;
  logic                          epend_q, epend_d;
  logic [GPI_W-1:0]              last_q, last_d;
  logic [NPG-1:0][15:0][7:0]     cap_q, cap_d;
`ifdef UFM_LOG_HDR_EN
  logic [31:0]                   seq_q, seq_d;
`endif

  logic          trig, erase_rise;
  logic [10:0]   slot_base;
  logic [PW-1:0] dp;
  logic          unused_rd;

  assign unused_rd  = ^mem_rd_data;
  assign trig       = en_save_i && ((gpi != last_q) || init_q);
  assign erase_rise = erase_req_i & ~erq_q;
  assign erq_d      = erase_req_i;
  assign slot_base  = BASE_PAGE + 11'(slot_q) * 11'(SLOT_PG);
  assign dp         = PW'(pg_q - GW'(HDR));

  // Changes seen during a save are not latched separately: IDLE compares gpi
  // against last_q, so every intermediate change coalesces into one snapshot.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    pg_d        = pg_q;
    page_d      = page_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    slot_d      = slot_q;
    wrap_d      = wrap_q;
    err_d       = err_q;
    init_d      = init_q;
    last_d      = last_q;
    cap_d       = cap_q;
    epend_d     = epend_q | erase_rise;
    save_done_o = 1'b0;
`ifdef UFM_LOG_HDR_EN
    seq_d       = seq_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (epend_q || erase_rise) begin
          // erase has priority; a simultaneous trigger is re-seen afterwards
          state_d = S_EKICK;
          epend_d = 1'b0;
          page_d  = BASE_PAGE;
        end else if (trig) begin
          state_d = S_FILL;
          cap_d   = gpi;
          last_d  = gpi;
          init_d  = 1'b0;
          byte_d  = '0;
          pg_d    = '0;
          retry_d = '0;
          page_d  = slot_base;
        end
      end
      S_FILL: begin
        byte_d = byte_q + 1'b1;
        if (byte_q == 4'd15) state_d = S_KICK;
      end
      S_KICK: begin
        tmo_d   = '0;
        state_d = S_WHI;
      end
      S_WHI: begin
        if (BUSY) state_d = S_WLO;
        else if (tmo_q > TW'(TMO)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_WLO: begin
        if (!BUSY) begin
          if (ERR && (retry_q < RW'(MAX_RETRY))) begin
            retry_d = retry_q + 1'b1;
            state_d = S_KICK;
          end else begin
            if (ERR) err_d = 1'b1;
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (pg_q == GW'(SLOT_PG - 1)) state_d = S_DONE;
        else begin
          pg_d    = pg_q + 1'b1;
          page_d  = page_q + 11'd1;
          retry_d = '0;
          state_d = S_FILL;
        end
      end
      S_DONE: begin
        save_done_o = 1'b1;
        state_d     = S_IDLE;
        if (slot_q == SW'(NUM_SLOTS - 1)) begin
          slot_d = '0;
          wrap_d = 1'b1;
        end else slot_d = slot_q + 1'b1;
`ifdef UFM_LOG_HDR_EN
        seq_d = seq_q + 32'd1;
`endif
      end
      S_EKICK: begin
        tmo_d   = '0;
        state_d = S_EHI;
      end
      S_EHI: begin
        if (BUSY) state_d = S_ELO;
        else if (tmo_q > TW'(TMO)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_ELO: begin
        if (!BUSY) begin
          slot_d  = '0;
          wrap_d  = 1'b0;
          err_d   = ERR;
          init_d  = 1'b1;
          state_d = S_IDLE;
`ifdef UFM_LOG_HDR_EN
          seq_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command outputs decode straight from state so they hold from KICK until
  // the BUSY handshake completes.
  always_comb begin
    cmd = 3'd0;
    GO  = 1'b0;
    case (state_q)
      S_KICK:         begin GO = 1'b1; cmd = 3'd2; end
      S_WHI, S_WLO:   cmd = 3'd2;
      S_EKICK:        begin GO = 1'b1; cmd = 3'd4; end
      S_EHI, S_ELO:   cmd = 3'd4;
      default:        ;
    endcase
  end

  always_comb begin
    mem_wr_data = cap_q[dp][byte_q];
`ifdef UFM_LOG_HDR_EN
    if (pg_q == '0) begin
      case (byte_q)
        4'd0:    mem_wr_data = seq_q[31:24];
        4'd1:    mem_wr_data = seq_q[23:16];
        4'd2:    mem_wr_data = seq_q[15:8];
        4'd3:    mem_wr_data = seq_q[7:0];
        4'd4:    mem_wr_data = 8'(NPG);
        4'd15:   mem_wr_data = 8'hA5;
        default: mem_wr_data = 8'h00;
      endcase
    end
`endif
  end

  assign mem_we   = (state_q == S_FILL);
  assign mem_ce   = (state_q == S_FILL);
  assign mem_addr = byte_q;
  assign ufm_page = page_q;
  assign busy_o   = (state_q != S_IDLE);
  assign err_o    = err_q;
  assign wrap_o   = wrap_q;
  assign slot_o   = slot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      pg_q    <= '0;
      page_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      slot_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      init_q  <= 1'b1;
      erq_q   <= 1'b0;
      epend_q <= 1'b0;
      last_q  <= '0;
      cap_q   <= '0;
`ifdef UFM_LOG_HDR_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      pg_q    <= pg_d;
      page_q  <= page_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      slot_q  <= slot_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      init_q  <= init_d;
      erq_q   <= erq_d;
      epend_q <= epend_d;
      last_q  <= last_d;
      cap_q   <= cap_d;
`ifdef UFM_LOG_HDR_EN
      seq_q   <= seq_d;
`endif
    end
  end
endmodule

// File: tb/tb_ufm_event_log.sv
module tb_ufm_event_log;
  localparam int GPI_W = 512;
  localparam int NPG   = GPI_W / 128;

  logic             clk = 1'b0;
  logic             rst, en_save, erase_req;
  logic [GPI_W-1:0] gpi;
  logic [2:0]       cmd;
  logic [10:0]      ufm_page;
  logic             GO, mem_we, mem_ce;
  logic             BUSY = 1'b0, ERR = 1'b0;
  logic [3:0]       mem_addr;
  logic [7:0]       mem_wr_data, mem_rd_data;
  logic             busy_o, save_done_o, err_o, wrap_o;
  logic [2:0]       slot_o;

  always #5 clk = ~clk;

  ufm_event_log dut (
    .clk_i(clk), .rst_i(rst), .en_save_i(en_save), .erase_req_i(erase_req),
    .gpi(gpi), .cmd(cmd), .ufm_page(ufm_page), .GO(GO), .BUSY(BUSY), .ERR(ERR),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy_o(busy_o), .save_done_o(save_done_o), .err_o(err_o),
    .wrap_o(wrap_o), .slot_o(slot_o)
  );

  int n_vec = 0, n_bad = 0;
  int go_cnt = 0, done_cnt = 0;

  typedef struct {
    logic [2:0]   cmd;
    logic [10:0]  page;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] wbuf [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_go(input logic [2:0] c, input logic [10:0] pg, input logic [127:0] d);
    exp_t e;
    e.cmd = c; e.page = pg; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_snap(input logic [GPI_W-1:0] v, input int slot);
    for (int p = 0; p < NPG; p++) push_go(3'd2, 11'(slot * NPG + p), v[p*128 +: 128]);
  endtask

  // Wait until the DUT has been idle for several consecutive cycles.
  task automatic wait_quiet(input string tag);
    int quiet = 0;
    int n = 0;
    @(negedge clk);
    while (quiet < 4 && n < 4000) begin
      @(negedge clk);
      n++;
      quiet = busy_o ? 0 : quiet + 1;
    end
    if (quiet < 4) chk(tag, 128'(busy_o), 128'(0));
  endtask

  // ufm_wb_top stand-in: BUSY rises two cycles after GO, stays up busy_len
  // cycles; ERR reported on the fall while err_left > 0.
  int err_left = 0;
  bit hang = 1'b0;
  int busy_len = 5;
  always begin
    @(negedge clk);
    if (GO && !rst && !hang) begin
      repeat (2) @(negedge clk);
      BUSY = 1'b1;
      repeat (busy_len) @(negedge clk);
      BUSY = 1'b0;
      ERR  = (err_left > 0);
      if (err_left > 0) err_left--;
    end
  end

  // Monitor: rebuilds the staged page from DPRAM writes, scoreboards each GO.
  always @(negedge clk) begin : mon
    logic [127:0] wd;
    exp_t e;
    if (!rst) begin
      if (mem_we || mem_ce) chk("ce_eq_we", 128'(mem_ce), 128'(mem_we));
      if (mem_we) wbuf[mem_addr] = mem_wr_data;
      if (save_done_o) done_cnt++;
      if (GO) begin
        go_cnt++;
        if (exp_q.size() == 0) chk("unexpected_go", 128'(cmd), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("go_cmd", 128'(cmd), 128'(e.cmd));
          if (e.cmd == 3'd2) begin
            for (int b = 0; b < 16; b++) wd[b*8 +: 8] = wbuf[b];
            chk("go_page", 128'(ufm_page), 128'(e.page));
            chk("go_data", wd, e.data);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [GPI_W-1:0] v;
    int g0, d0;
    rst = 1'b1; en_save = 1'b0; erase_req = 1'b0; gpi = '0; mem_rd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_outs", 128'({GO, cmd, ufm_page, mem_we, save_done_o}), 128'(0));
    chk("rst_flags", 128'({err_o, wrap_o, slot_o}), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_en", 128'(busy_o), 128'(0));

    // forced snapshot after reset, with latency checks
    push_snap(gpi, 0);
    g0 = go_cnt; d0 = done_cnt;
    en_save = 1'b1;
    @(negedge clk);
    chk("trig_to_we", 128'({mem_we, mem_addr}), 128'({1'b1, 4'd0}));
    repeat (16) @(negedge clk);
    chk("fill_to_go", 128'({GO, cmd}), 128'({1'b1, 3'd2}));
    wait_quiet("wq_forced");
    chk("forced_gos", 128'(go_cnt - g0), 128'(4));
    chk("forced_done", 128'(done_cnt - d0), 128'(1));
    chk("forced_slot", 128'(slot_o), 128'(1));

    // byte placement on pages 0 and 1 of slot 1
    v = gpi; v[7:0] = 8'h5A; v[135:128] = 8'h3C;
    push_snap(v, 1);
    gpi = v;
    wait_quiet("wq_bytes");
    chk("bytes_slot", 128'(slot_o), 128'(2));

    // three changes during one save coalesce into one extra snapshot
    d0 = done_cnt;
    v = {16{32'h1111_0001}}; push_snap(v, 2); gpi = v;
    repeat (20) @(negedge clk); gpi = {16{32'h2222_0002}};
    repeat (20) @(negedge clk); gpi = {16{32'h3333_0003}};
    repeat (20) @(negedge clk);
    v = {16{32'h4444_0004}}; push_snap(v, 3); gpi = v;
    wait_quiet("wq_coal");
    chk("coal_done", 128'(done_cnt - d0), 128'(2));
    chk("coal_slot", 128'(slot_o), 128'(4));

    // fill remaining slots and wrap
    for (int s = 4; s < 9; s++) begin
      for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
      push_snap(v, s % 8);
      gpi = v;
      wait_quiet("wq_wrap");
      if (s == 6) chk("wrap_before", 128'(wrap_o), 128'(0));
      if (s == 7) chk("wrap_slot0", 128'({wrap_o, slot_o}), 128'({1'b1, 3'd0}));
    end
    chk("wrap_after9", 128'({wrap_o, slot_o}), 128'({1'b1, 3'd1}));

    // two ERRs: two retries to the same page, no error
    err_left = 2; g0 = go_cnt;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
    push_go(3'd2, 11'd4, v[127:0]);
    push_go(3'd2, 11'd4, v[127:0]);
    push_snap(v, 1);
    gpi = v;
    wait_quiet("wq_retry");
    chk("retry_gos", 128'(go_cnt - g0), 128'(6));
    chk("retry_err", 128'(err_o), 128'(0));

    // three ERRs: retries exhausted, error sticks, snapshot continues
    err_left = 3;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
    push_go(3'd2, 11'd8, v[127:0]);
    push_go(3'd2, 11'd8, v[127:0]);
    push_snap(v, 2);
    gpi = v;
    wait_quiet("wq_err3");
    chk("err3_err", 128'(err_o), 128'(1));

    // erase clears error, slot and wrap
    en_save = 1'b0;
    push_go(3'd4, 11'd0, 128'd0);
    erase_req = 1'b1;
    wait_quiet("wq_erase1");
    chk("erase1_flags", 128'({err_o, wrap_o, slot_o}), 128'(0));
    erase_req = 1'b0;

    // watchdog: BUSY never rises; forced snapshot after erase aborts
    hang = 1'b1;
    push_go(3'd2, 11'd0, gpi[127:0]);
    en_save = 1'b1;
    wait_quiet("wq_tmo");
    chk("tmo_err", 128'(err_o), 128'(1));
    chk("tmo_slot", 128'(slot_o), 128'(1));
    en_save = 1'b0; hang = 1'b0;
    push_go(3'd4, 11'd0, 128'd0);
    erase_req = 1'b1;
    wait_quiet("wq_erase2");
    chk("erase2_flags", 128'({err_o, slot_o}), 128'(0));
    erase_req = 1'b0;
    repeat (3) @(negedge clk);

    // erase requested mid-save runs after the snapshot; en_save dropped too
    d0 = done_cnt;
    push_snap(gpi, 0);
    push_go(3'd4, 11'd0, 128'd0);
    en_save = 1'b1;
    repeat (2) @(negedge clk);
    en_save = 1'b0;
    repeat (20) @(negedge clk);
    erase_req = 1'b1;
    wait_quiet("wq_erase3");
    chk("mid_done", 128'(done_cnt - d0), 128'(1));
    chk("mid_slot", 128'({err_o, slot_o}), 128'(0));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
